// File: rtl/pso_seq_arbiter_if.sv
// Bundle between the power-management register file, the PSO sequencer
// and the per-domain PSO state machines.
interface pso_seq_arbiter_if #(
    parameter int unsigned NUM_DOM = 4
);
    localparam int unsigned IDW = $clog2(NUM_DOM);

    logic [NUM_DOM-1:0] sw_req;
    logic               sched_en;
    logic [NUM_DOM-1:0] pwr1_on;
    logic [NUM_DOM-1:0] clr_status;
    logic [NUM_DOM-1:0] err_clr;

    logic [NUM_DOM-1:0] L1_module_req;
    logic               grant_vld;
    logic [IDW-1:0]     grant_id;
    logic               grant_dir;
    logic               seq_done;
    logic [NUM_DOM-1:0] timeout_err;

    // Register file / downstream side: drives requests and status.
    modport master (
        output sw_req, sched_en, pwr1_on, clr_status, err_clr,
        input  L1_module_req, grant_vld, grant_id, grant_dir, seq_done, timeout_err
    );

    // Sequencer side.
    modport slave (
        input  sw_req, sched_en, pwr1_on, clr_status, err_clr,
        output L1_module_req, grant_vld, grant_id, grant_dir, seq_done, timeout_err
    );
endinterface

// File: rtl/pso_seq_arbiter.sv
// PSO transition sequencer: grants one power-domain transition at a time
// in round-robin order, waits for its completion (or a timeout), then holds
// a settling gap before the next grant.
module pso_seq_arbiter #(
    parameter int unsigned NUM_DOM = 4,
    parameter int unsigned GAP_CYC = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              pclk,
    input  logic              nprst,
    pso_seq_arbiter_if.slave  bus
);
    localparam int unsigned IDW = $clog2(NUM_DOM);
    localparam int unsigned TW  = $clog2(TIMEOUT);
    localparam int unsigned GW  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_DOM - 1);
    localparam logic [TW-1:0]  TIMER_MAX = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0]  GAP_MAX   = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DONE = 2'd1,
        ST_GAP       = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [NUM_DOM-1:0] l1_req_q, l1_req_d;
    logic               vld_q,    vld_d;
    logic [IDW-1:0]     id_q,     id_d;
    logic               dir_q,    dir_d;
    logic               done_q,   done_d;
    logic [NUM_DOM-1:0] err_q,    err_d;
    logic [IDW-1:0]     rr_q,     rr_d;
    logic [TW-1:0]      timer_q,  timer_d;
    logic [GW-1:0]      gap_q,    gap_d;

    logic [NUM_DOM-1:0] pend_c;
    logic               found_c;
    logic [IDW-1:0]     win_c;
    logic [IDW-1:0]     cand_c;
    logic               complete_c;
    logic [NUM_DOM-1:0] err_set_c;

    // Domains whose requested state differs from what has been granted.
    assign pend_c = bus.sw_req ^ l1_req_q;

    // Round-robin pick: first pending domain at or after rr_q, wrapping.
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        cand_c  = '0;
        for (int unsigned k = 0; k < NUM_DOM; k++) begin
            cand_c = IDW'((32'(rr_q) + k) % NUM_DOM);
            if (!found_c && pend_c[cand_c]) begin
                found_c = 1'b1;
                win_c   = cand_c;
            end
        end
    end

    // Completion of the granted domain: gate-1 off for a power-down,
    // power-up-complete pulse for a power-up. Used unregistered.
    assign complete_c = dir_q ? ~bus.pwr1_on[id_q] : bus.clr_status[id_q];

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        l1_req_d  = l1_req_q;
        vld_d     = vld_q;
        id_d      = id_q;
        dir_d     = dir_q;
        done_d    = 1'b0;
        rr_d      = rr_q;
        timer_d   = timer_q;
        gap_d     = gap_q;
        err_set_c = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.sched_en && found_c) begin
                    l1_req_d[win_c] = bus.sw_req[win_c];
                    id_d            = win_c;
                    dir_d           = bus.sw_req[win_c];
                    rr_d            = (win_c == LAST_ID) ? '0 : win_c + IDW'(1);
                    timer_d         = '0;
                    vld_d           = 1'b1;
                    state_d         = ST_WAIT_DONE;
                end
            end

            ST_WAIT_DONE: begin
                if (complete_c) begin
                    done_d  = 1'b1;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else if (timer_q == TIMER_MAX) begin
                    // Abandon the grant; the request bit is left as issued.
                    err_set_c[id_q] = 1'b1;
                    done_d          = 1'b1;
                    gap_d           = '0;
                    state_d         = ST_GAP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            ST_GAP: begin
                if (gap_q == GAP_MAX) begin
                    vld_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end

            default: begin
                vld_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // A new timeout wins over a same-cycle clear on the same bit.
        err_d = (err_q & ~bus.err_clr) | err_set_c;
    end

    // State and output registers.
    always_ff @(posedge pclk or negedge nprst) begin
        if (!nprst) begin
            state_q  <= ST_IDLE;
            l1_req_q <= '0;
            vld_q    <= 1'b0;
            id_q     <= '0;
            dir_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= '0;
            rr_q     <= '0;
            timer_q  <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            l1_req_q <= l1_req_d;
            vld_q    <= vld_d;
            id_q     <= id_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rr_q     <= rr_d;
            timer_q  <= timer_d;
            gap_q    <= gap_d;
        end
    end

    assign bus.L1_module_req = l1_req_q;
    assign bus.grant_vld     = vld_q;
    assign bus.grant_id      = id_q;
    assign bus.grant_dir     = dir_q;
    assign bus.seq_done      = done_q;
    assign bus.timeout_err   = err_q;
endmodule

// File: tb/tb_pso_seq_arbiter.sv
// Randomized bench for pso_seq_arbiter against a timestamp-based reference
// model, with a small emulation of the downstream PSO state machines.
module tb_pso_seq_arbiter;
    localparam int unsigned N   = 4;
    localparam int unsigned GAP = 8;
    localparam int unsigned TO  = 64;

    logic pclk = 1'b0;
    logic nprst;
    always #5 pclk = ~pclk;

    pso_seq_arbiter_if #(.NUM_DOM(N)) bus ();

    pso_seq_arbiter #(
        .NUM_DOM (N),
        .GAP_CYC (GAP),
        .TIMEOUT (TO)
    ) dut (
        .pclk  (pclk),
        .nprst (nprst),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: one in-flight grant described by its grant edge and
    // its finish edge; the next grant is allowed only after GAP more edges.
    int         cyc;
    logic [N-1:0] m_l1, m_err;
    int         m_id, m_rr;
    logic       m_dir, m_done, m_vld, m_busy;
    int         g_t, fin_t;

    // Downstream emulation.
    bit         emu_on;
    int         dn_cnt[N];
    int         up_cnt[N];
    logic [N-1:0] prev_l1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0h want %0h", tag, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; m_l1 = '0; m_err = '0; m_id = 0; m_rr = 0;
        m_dir = 0; m_done = 0; m_vld = 0; m_busy = 0; g_t = 0; fin_t = -1;
    endtask

    // Advance the model across one active edge using the inputs now applied.
    task automatic model_edge();
        logic [N-1:0] set;
        logic [N-1:0] pend;
        bit comp;
        bit found;
        int j;
        cyc++;
        m_done = 0;
        set = '0;
        if (m_busy) begin
            if (fin_t < 0) begin
                comp = m_dir ? !bus.pwr1_on[m_id] : bus.clr_status[m_id];
                if (comp || (cyc - g_t) == int'(TO)) begin
                    fin_t  = cyc;
                    m_done = 1;
                    if (!comp) set[m_id] = 1'b1;
                end
            end else if ((cyc - fin_t) == int'(GAP)) begin
                m_busy = 0;
                m_vld  = 0;
            end
        end else if (bus.sched_en) begin
            pend  = bus.sw_req ^ m_l1;
            found = 0;
            for (int k = 0; k < int'(N); k++) begin
                j = (m_rr + k) % int'(N);
                if (!found && pend[j]) begin
                    found = 1;
                    m_id  = j;
                end
            end
            if (found) begin
                m_l1[m_id] = bus.sw_req[m_id];
                m_dir      = bus.sw_req[m_id];
                m_rr       = (m_id + 1) % int'(N);
                g_t        = cyc;
                fin_t      = -1;
                m_busy     = 1;
                m_vld      = 1;
            end
        end
        m_err = (m_err & ~bus.err_clr) | set;
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".l1"},   32'(bus.L1_module_req), 32'(m_l1));
        check_eq({tag, ".vld"},  32'(bus.grant_vld),     32'(m_vld));
        check_eq({tag, ".id"},   32'(bus.grant_id),      32'(m_id));
        check_eq({tag, ".dir"},  32'(bus.grant_dir),     32'(m_dir));
        check_eq({tag, ".done"}, 32'(bus.seq_done),      32'(m_done));
        check_eq({tag, ".err"},  32'(bus.timeout_err),   32'(m_err));
    endtask

    // One clock: model steps, DUT clocks, outputs compared at the falling edge.
    task automatic cycle();
        model_edge();
        @(posedge pclk);
        @(negedge pclk);
        compare_all("cyc");
    endtask

    task automatic emu_reset();
        for (int i = 0; i < int'(N); i++) begin
            dn_cnt[i] = -1;
            up_cnt[i] = -1;
        end
        bus.pwr1_on    = '1;
        bus.clr_status = '0;
        prev_l1        = bus.L1_module_req;
    endtask

    // Downstream PSO machines: power down/up some cycles after the request
    // changes, occasionally far too late, plus stray clr_status pulses.
    task automatic emu_step();
        logic [N-1:0] l1;
        l1 = bus.L1_module_req;
        bus.clr_status = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (l1[i] && !prev_l1[i])
                dn_cnt[i] = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, 12));
            if (!l1[i] && prev_l1[i])
                up_cnt[i] = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, 12));
            if (dn_cnt[i] == 0) begin
                bus.pwr1_on[i] = 1'b0;
                dn_cnt[i] = -1;
            end else if (dn_cnt[i] > 0) begin
                dn_cnt[i]--;
            end
            if (up_cnt[i] == 0) begin
                bus.pwr1_on[i]    = 1'b1;
                bus.clr_status[i] = 1'b1;
                up_cnt[i] = -1;
            end else if (up_cnt[i] > 0) begin
                up_cnt[i]--;
            end
        end
        if ($urandom_range(0, 19) == 0)
            bus.clr_status[$urandom_range(0, N - 1)] = 1'b1;
        prev_l1 = l1;
    endtask

    task automatic do_reset();
        nprst = 1'b0;
        #1;
        model_reset();
        compare_all("rst");
        @(negedge pclk);
        @(negedge pclk);
        emu_reset();
        nprst = 1'b1;
    endtask

    initial begin
        bit did_rst;
        int guard;
        did_rst        = 0;
        emu_on         = 0;
        bus.sw_req     = '0;
        bus.sched_en   = 1'b1;
        bus.err_clr    = '0;
        emu_reset();
        nprst = 1'b0;
        model_reset();
        repeat (3) @(negedge pclk);
        compare_all("por");
        nprst = 1'b1;

        // Timeout: domain 2 never reports power-off.
        bus.sw_req = 4'b0100;
        cycle();
        check_eq("to_grant_l1", 32'(bus.L1_module_req), 32'h4);
        check_eq("to_grant_id", 32'(bus.grant_id), 32'd2);
        repeat (TO - 1) cycle();
        check_eq("to_early", 32'(bus.timeout_err), 32'h0);
        cycle();
        check_eq("to_set", 32'(bus.timeout_err), 32'h4);
        check_eq("to_done", 32'(bus.seq_done), 32'h1);
        check_eq("to_l1_kept", 32'(bus.L1_module_req), 32'h4);
        bus.err_clr = 4'b0100;
        cycle();
        bus.err_clr = '0;
        check_eq("err_clr", 32'(bus.timeout_err), 32'h0);

        // sched_en gating: nothing granted while disabled.
        guard = 0;
        while (m_busy && guard < 100) begin
            cycle();
            guard++;
        end
        check_eq("idle_bound", 32'(m_busy), 32'h0);
        bus.sched_en = 1'b0;
        bus.sw_req   = 4'b0111;
        repeat (10) cycle();
        check_eq("gated_l1", 32'(bus.L1_module_req), 32'h4);
        bus.sched_en = 1'b1;

        // Randomized traffic with downstream emulation.
        emu_on = 1;
        emu_reset();
        for (int it = 0; it < 3000; it++) begin
            if (emu_on) emu_step();
            if ($urandom_range(0, 4) == 0)
                bus.sw_req[$urandom_range(0, N - 1)] = ~bus.sw_req[$urandom_range(0, N - 1)];
            if ($urandom_range(0, 29) == 0)
                bus.sched_en = ~bus.sched_en;
            bus.err_clr = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
            if (it >= 1500 && !did_rst && m_busy && fin_t < 0) begin
                did_rst = 1;
                do_reset();
            end else begin
                cycle();
            end
        end
        check_eq("mid_reset_hit", 32'(did_rst), 32'h1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/pso_seq_arbiter.md
# pso_seq_arbiter

Schedules power-shut-off (PSO) transitions across several power domains so that at most one domain switches its power gates at a time, bounding inrush current on the shared supply. It sits between the power-management register file and the per-domain PSO state machines. It turns software-level per-domain requests into the L1 request inputs of those state machines, one grant at a time, using round-robin selection. It enforces a settling gap between transitions and flags domains whose transition does not complete within a timeout.

## Interface
- NUM_DOM, 4: number of power domains (2..8)
- GAP_CYC, 8: settling cycles between completion of one transition and the next grant (≥1)
- TIMEOUT, 64: cycles allowed in WAIT_DONE before the grant is abandoned (≥2; covers the ~36-cycle downstream power-up)
- pclk  input  1  clock
- nprst  input  1  asynchronous active-low reset
- sw_req  input  NUM_DOM  requested L1 state per domain from registers (1 = power down)
- sched_en  input  1  when 0, no new grants; an in-flight transition still completes
- pwr1_on  input  NUM_DOM  per-domain power-gate-1 status from the PSO state machines
- clr_status  input  NUM_DOM  per-domain one-cycle power-up-complete pulse from the PSO state machines
- err_clr  input  NUM_DOM  write-1 pulse that clears the matching timeout_err bit
- L1_module_req  output  NUM_DOM  registered L1 request to each PSO state machine
- grant_vld  output  1  a transition is in flight (WAIT_DONE or GAP)
- grant_id  output  clog2(NUM_DOM)  domain holding the current or last grant
- grant_dir  output  1  direction of the current grant (1 = down, 0 = up)
- seq_done  output  1  one-cycle pulse when a transition completes or times out
- timeout_err  output  NUM_DOM  sticky per-domain timeout flags

## Operation
- Pending vector: pend[i] = sw_req[i] ^ L1_module_req[i]. Requests are only evaluated in IDLE.
- FSM states: IDLE, WAIT_DONE, GAP.
- IDLE:
  - If sched_en=1 and pend≠0, select winner w as the first pending index at or after rr_ptr, with wrap-around.
  - On that edge: L1_module_req[w] <= sw_req[w]; grant_id <= w; grant_dir <= sw_req[w]; rr_ptr <= (w+1) mod NUM_DOM; timer <= 0; go to WAIT_DONE.
- WAIT_DONE completion condition:
  - grant_dir=1: pwr1_on[w]=0 (downstream reached Pwr_off).
  - grant_dir=0: clr_status[w]=1.
- WAIT_DONE exits:
  - On completion: seq_done=1 for one cycle; gap counter <= 0; go to GAP.
  - Otherwise timer increments. When timer reaches TIMEOUT-1 without completion: set timeout_err[w], pulse seq_done, go to GAP.
  - L1_module_req[w] is not changed on timeout.
- GAP: the counter runs 0..GAP_CYC-1, then the FSM goes to IDLE.
- L1_module_req bits change only on a grant edge. Changes to sw_req[w] while its grant is in flight are ignored until the FSM returns to IDLE. At that point the mismatch is pending again and competes normally.
- sched_en=0 affects only the IDLE decision.
- timeout_err:
  - A set and an err_clr on the same bit in the same cycle: set wins.
  - err_clr on other bits takes effect independently.
- pwr1_on and clr_status for non-granted domains are ignored.

## Timing
- Reset values: state=IDLE, L1_module_req=0, grant_vld=0, grant_id=0, grant_dir=0, seq_done=0, timeout_err=0, rr_ptr=0, timer=0, gap counter=0.
- Request to grant: sw_req change sampled in IDLE → L1_module_req updates on the next pclk edge (1 cycle).
- Minimum spacing: grant edge to next grant edge ≥ 1 (done detect) + GAP_CYC + 1 cycles.
- grant_vld is 1 from the cycle after the grant edge through the last GAP cycle. It is 0 in IDLE.
- The done inputs are used unregistered: completion is detected on the edge where pwr1_on/clr_status is sampled.
- Reset asserted mid-transition returns every output to its reset value asynchronously. All domains then see L1_module_req=0.

## Test plan
- Single down/up:
  - NUM_DOM=4, sw_req=0001 → L1_module_req=0001 one cycle later, grant_id=0, grant_dir=1.
  - Model pwr1_on[0] falling 6 cycles later → seq_done pulse, 8 GAP cycles, then IDLE.
  - Clear sw_req[0] → L1_module_req=0000; clr_status[0] pulse → seq_done.
- Round-robin:
  - sw_req=1111 simultaneously → grants in order 0,1,2,3.
  - Successive grant edges are ≥10 cycles apart, and only one L1_module_req bit changes per grant.
- Timeout:
  - sw_req=0100, pwr1_on[2] held 1 → timeout_err=0100 exactly 64 cycles after the grant edge; L1_module_req[2] stays 1.
  - err_clr=0100 → timeout_err=0000.
- Late withdrawal: sw_req[1] 1→0 two cycles after its grant → no L1 change until done+GAP, then a power-up grant for domain 1.
- sched_en gating:
  - sched_en=0 with sw_req=0011 → no grant.
  - Set sched_en=1 → domain 0 is granted; drop sched_en mid-WAIT_DONE → domain 0 completes, domain 1 waits.
- Reset mid-WAIT_DONE: assert nprst=0 → all outputs at reset values immediately; after release, the re-pending domain is granted from rr_ptr=0.
